up_adc_rx_aggr: RTL and testbench

Parametrised processor-bus and status aggregator for multi-channel ADC receive cores. It generalises the fixed four-channel fan-in to NUM_CHANNELS channel register banks plus one common bank. Each cycle it combines their write acks, read acks, read data and status flags into one registered response. It adds a bus-timeout watchdog, ack-collision detection and per-channel sticky PN-error capture. It sits in the up_clk domain between the AXI-lite-to-up bridge and the up_adc_common/channel register blocks.

---
 rtl/up_adc_rx_aggr.sv | 171 +++++++++++++++++
 tb/tb_up_adc_rx_aggr.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_adc_rx_aggr.sv
`default_nettype none
// ============================================================================
// Module   : up_adc_rx_aggr
// Brief    : Processor-bus ack/data/status aggregator for NUM_CHANNELS ADC
//            channel banks plus one common bank, with ack-collision and
//            sticky PN-error capture. Optional bus watchdog is built when
//            UP_ADC_RX_AGGR_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module up_adc_rx_aggr #(
    parameter int          NUM_CHANNELS   = 4,
    parameter int          TIMEOUT_CYCLES = 32,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_DEAD
) (
    input  logic                            up_clk,
    input  logic                            up_rstn,
    input  logic                            up_wreq,
    input  logic                            up_rreq,
    input  logic [NUM_CHANNELS:0]           up_wack_s,
    input  logic [NUM_CHANNELS:0]           up_rack_s,
    input  logic [32*(NUM_CHANNELS+1)-1:0]  up_rdata_s,
    input  logic [NUM_CHANNELS-1:0]         up_adc_pn_err_s,
    input  logic [NUM_CHANNELS-1:0]         up_adc_pn_oos_s,
    input  logic [NUM_CHANNELS-1:0]         up_adc_or_s,
    input  logic                            up_err_clr,
    output logic                            up_wack,
    output logic                            up_rack,
    output logic [31:0]                     up_rdata,
    output logic                            up_status_pn_err,
    output logic                            up_status_pn_oos,
    output logic                            up_status_or,
    output logic [7:0]                      up_usr_chanmax,
    output logic                            up_err_timeout,
    output logic                            up_err_collision,
    output logic [NUM_CHANNELS-1:0]         up_pn_err_sticky
);

    localparam int                   c_NUM_SLAVES = NUM_CHANNELS + 1;
    localparam logic [NUM_CHANNELS:0] c_SLAVE_ONE = {{NUM_CHANNELS{1'b0}}, 1'b1};

    logic                    r_wack;
    logic                    r_rack;
    logic [31:0]             r_rdata;
    logic                    r_status_pn_err;
    logic                    r_status_pn_oos;
    logic                    r_status_or;
    logic                    r_err_collision;
    logic [NUM_CHANNELS-1:0] r_pn_err_sticky;

    logic        w_wack_any;
    logic        w_rack_any;
    logic        w_collision;
    logic [31:0] w_rdata_or;
    logic [1:0]  w_fire;        // [0] write watchdog, [1] read watchdog

    assign w_wack_any = |up_wack_s;
    assign w_rack_any = |up_rack_s;

    // v & (v-1) is non-zero exactly when more than one bit of v is set
    assign w_collision = (|(up_wack_s & (up_wack_s - c_SLAVE_ONE))) |
                         (|(up_rack_s & (up_rack_s - c_SLAVE_ONE)));

    always_comb begin
        w_rdata_or = '0;
        for (int k = 0; k < c_NUM_SLAVES; k++) begin
            if (up_rack_s[k]) begin
                w_rdata_or = w_rdata_or | up_rdata_s[32*k +: 32];
            end
        end
    end

`ifdef UP_ADC_RX_AGGR_TIMEOUT_EN
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } trk_state_t;

    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0] w_req;
    logic [1:0] w_ack;
    logic       r_err_timeout;

    assign w_req = {up_rreq, up_wreq};
    assign w_ack = {w_rack_any, w_wack_any};

    for (genvar t = 0; t < 2; t++) begin : g_trk
        trk_state_t r_state;
        logic [7:0] r_cnt;

        // A real ack on the expiry edge takes priority over the synthetic one
        assign w_fire[t] = (r_state == S_WAIT) && !w_ack[t] && (r_cnt == c_CNT_LAST);

        always_ff @(posedge up_clk or negedge up_rstn) begin
            if (!up_rstn) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_req[t]) begin
                            r_state <= S_WAIT;
                            r_cnt   <= '0;
                        end
                    end
                    S_WAIT: begin
                        if (w_ack[t] || (r_cnt == c_CNT_LAST)) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= (|w_fire) | (r_err_timeout & ~up_err_clr);
        end
    end

    assign up_err_timeout = r_err_timeout;
`else
    logic w_unused_req;

    assign w_unused_req   = up_wreq | up_rreq;
    assign w_fire         = 2'b00;
    assign up_err_timeout = 1'b0;
`endif

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            r_wack          <= 1'b0;
            r_rack          <= 1'b0;
            r_rdata         <= '0;
            r_status_pn_err <= 1'b0;
            r_status_pn_oos <= 1'b0;
            r_status_or     <= 1'b0;
            r_err_collision <= 1'b0;
            r_pn_err_sticky <= '0;
        end else begin
            r_wack          <= w_wack_any | w_fire[0];
            r_rack          <= w_rack_any | w_fire[1];
            r_rdata         <= w_fire[1] ? ERR_RDATA : w_rdata_or;
            r_status_pn_err <= |up_adc_pn_err_s;
            r_status_pn_oos <= |up_adc_pn_oos_s;
            r_status_or     <= |up_adc_or_s;
            // Sticky flags: a new event in the clear cycle keeps the flag set
            r_err_collision <= w_collision | (r_err_collision & ~up_err_clr);
            r_pn_err_sticky <= up_adc_pn_err_s |
                               (r_pn_err_sticky & ~{NUM_CHANNELS{up_err_clr}});
        end
    end

    assign up_wack          = r_wack;
    assign up_rack          = r_rack;
    assign up_rdata         = r_rdata;
    assign up_status_pn_err = r_status_pn_err;
    assign up_status_pn_oos = r_status_pn_oos;
    assign up_status_or     = r_status_or;
    assign up_err_collision = r_err_collision;
    assign up_pn_err_sticky = r_pn_err_sticky;
    assign up_usr_chanmax   = 8'(NUM_CHANNELS - 1);

endmodule
`default_nettype wire

// File: tb/tb_up_adc_rx_aggr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_up_adc_rx_aggr
// Brief    : Scoreboard bench for up_adc_rx_aggr (4- and 16-channel builds);
//            watchdog expectations follow UP_ADC_RX_AGGR_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_up_adc_rx_aggr;

    localparam int NCH = 4;
    localparam int NS  = NCH + 1;
    localparam int TO  = 8;

    typedef struct {
        logic [33:0] v;     // {wack, rack, rdata}
        int          cyc;   // edge count after which the ack is visible
    } exp_t;

    logic up_clk = 1'b0;
    always #5 up_clk = ~up_clk;

    int cyc = 0;
    always @(posedge up_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // 4-channel DUT
    logic                up_rstn, up_wreq, up_rreq, up_err_clr;
    logic [NS-1:0]       up_wack_s, up_rack_s;
    logic [32*NS-1:0]    up_rdata_s;
    logic [NCH-1:0]      pn_err, pn_oos, or_s;
    logic                up_wack, up_rack, st_pn_err, st_pn_oos, st_or;
    logic [31:0]         up_rdata;
    logic [7:0]          chanmax;
    logic                err_timeout, err_collision;
    logic [NCH-1:0]      pn_sticky;

    // 16-channel DUT
    logic [16:0]         rack16;
    logic [16:0]         zero17;
    logic [32*17-1:0]    rdata16_s;
    logic [15:0]         zero16;
    logic                wack16, rack16_o, st16_a, st16_b, st16_c, to16, col16;
    logic [31:0]         rdata16;
    logic [7:0]          chanmax16;
    logic [15:0]         sticky16;

    up_adc_rx_aggr #(.NUM_CHANNELS(NCH), .TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEAD_DEAD)) dut (
        .up_clk(up_clk), .up_rstn(up_rstn), .up_wreq(up_wreq), .up_rreq(up_rreq),
        .up_wack_s(up_wack_s), .up_rack_s(up_rack_s), .up_rdata_s(up_rdata_s),
        .up_adc_pn_err_s(pn_err), .up_adc_pn_oos_s(pn_oos), .up_adc_or_s(or_s),
        .up_err_clr(up_err_clr), .up_wack(up_wack), .up_rack(up_rack), .up_rdata(up_rdata),
        .up_status_pn_err(st_pn_err), .up_status_pn_oos(st_pn_oos), .up_status_or(st_or),
        .up_usr_chanmax(chanmax), .up_err_timeout(err_timeout),
        .up_err_collision(err_collision), .up_pn_err_sticky(pn_sticky)
    );

    up_adc_rx_aggr #(.NUM_CHANNELS(16), .TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEAD_DEAD)) dut16 (
        .up_clk(up_clk), .up_rstn(up_rstn), .up_wreq(1'b0), .up_rreq(1'b0),
        .up_wack_s(zero17), .up_rack_s(rack16), .up_rdata_s(rdata16_s),
        .up_adc_pn_err_s(zero16), .up_adc_pn_oos_s(zero16), .up_adc_or_s(zero16),
        .up_err_clr(1'b0), .up_wack(wack16), .up_rack(rack16_o), .up_rdata(rdata16),
        .up_status_pn_err(st16_a), .up_status_pn_oos(st16_b), .up_status_or(st16_c),
        .up_usr_chanmax(chanmax16), .up_err_timeout(to16),
        .up_err_collision(col16), .up_pn_err_sticky(sticky16)
    );

    exp_t q4[$];
    exp_t q16[$];
    exp_t e4, e16;

    // Monitors: every ack the DUT presents must match the oldest expectation
    always @(negedge up_clk) begin
        if (up_wack || up_rack) begin
            n_checks++;
            if (q4.size() == 0) begin
                n_errors++;
                $display("FAIL ack4_unexpected: got wack=%0b rack=%0b rdata=%h at cycle %0d, required no ack",
                         up_wack, up_rack, up_rdata, cyc);
            end else begin
                e4 = q4.pop_front();
                if ({up_wack, up_rack, up_rdata} !== e4.v || cyc != e4.cyc) begin
                    n_errors++;
                    $display("FAIL ack4: got {w,r,data}=%h at cycle %0d, required %h at cycle %0d",
                             {up_wack, up_rack, up_rdata}, cyc, e4.v, e4.cyc);
                end
            end
        end
    end

    always @(negedge up_clk) begin
        if (wack16 || rack16_o) begin
            n_checks++;
            if (q16.size() == 0) begin
                n_errors++;
                $display("FAIL ack16_unexpected: got wack=%0b rack=%0b rdata=%h, required no ack",
                         wack16, rack16_o, rdata16);
            end else begin
                e16 = q16.pop_front();
                if ({wack16, rack16_o, rdata16} !== e16.v || cyc != e16.cyc) begin
                    n_errors++;
                    $display("FAIL ack16: got {w,r,data}=%h at cycle %0d, required %h at cycle %0d",
                             {wack16, rack16_o, rdata16}, cyc, e16.v, e16.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge up_clk);
        #1;
    endtask

    task automatic push4(input logic w, input logic r, input logic [31:0] d, input int at);
        exp_t e;
        e.v   = {w, r, d};
        e.cyc = at;
        q4.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int c;
        exp_t e;
        up_rstn = 1'b0; up_wreq = 1'b0; up_rreq = 1'b0; up_err_clr = 1'b0;
        up_wack_s = '0; up_rack_s = '0; up_rdata_s = '0;
        pn_err = '0; pn_oos = '0; or_s = '0;
        rack16 = '0; zero17 = '0; rdata16_s = '0; zero16 = '0;

        // Reset state
        step(3);
        chk("rst_wack", 32'(up_wack), 0);
        chk("rst_rack", 32'(up_rack), 0);
        chk("rst_rdata", up_rdata, 0);
        chk("rst_status", 32'({st_pn_err, st_pn_oos, st_or}), 0);
        chk("rst_flags", 32'({err_timeout, err_collision}), 0);
        chk("rst_sticky", 32'(pn_sticky), 0);
        chk("chanmax4", 32'(chanmax), 3);
        chk("chanmax16", 32'(chanmax16), 15);
        up_rstn = 1'b1;
        step(2);

        // Normal read: req, then slave-2 ack one cycle later; slave 0 data must be masked
        up_rreq = 1'b1;
        step(1);
        up_rreq = 1'b0;
        up_rack_s = 5'b00100;
        up_rdata_s[2*32 +: 32] = 32'h1234_5678;
        up_rdata_s[0*32 +: 32] = 32'hFFFF_0000;
        push4(1'b0, 1'b1, 32'h1234_5678, cyc + 1);
        step(1);
        up_rack_s = '0; up_rdata_s = '0;
        step(1);
        chk("read_no_timeout", 32'(err_timeout), 0);

        // Unsolicited write ack
        up_wack_s = 5'b01000;
        push4(1'b1, 1'b0, 32'h0, cyc + 1);
        step(1);
        up_wack_s = '0;
        step(1);
        chk("single_ack_no_collision", 32'(err_collision), 0);

        // Write collision, then clear
        up_wack_s = 5'b10001;
        push4(1'b1, 1'b0, 32'h0, cyc + 1);
        step(1);
        up_wack_s = '0;
        chk("wr_collision_set", 32'(err_collision), 1);
        up_err_clr = 1'b1;
        step(1);
        up_err_clr = 1'b0;
        chk("wr_collision_clr", 32'(err_collision), 0);

        // Read collision: data of both acking slaves OR'd
        up_rack_s = 5'b00011;
        up_rdata_s[0*32 +: 32] = 32'h0000_00F0;
        up_rdata_s[1*32 +: 32] = 32'h0000_000F;
        push4(1'b0, 1'b1, 32'h0000_00FF, cyc + 1);
        step(1);
        up_rack_s = '0; up_rdata_s = '0;
        chk("rd_collision_set", 32'(err_collision), 1);
        up_err_clr = 1'b1;
        step(1);
        up_err_clr = 1'b0;
        chk("rd_collision_clr", 32'(err_collision), 0);

        // Sticky PN error and status ORs
        pn_err = 4'b0010;
        step(1);
        pn_err = '0;
        chk("pn_sticky_set", 32'(pn_sticky), 32'h2);
        chk("status_pn_err_hi", 32'(st_pn_err), 1);
        step(1);
        chk("status_pn_err_lo", 32'(st_pn_err), 0);
        chk("pn_sticky_hold", 32'(pn_sticky), 32'h2);
        pn_err = 4'b0010; up_err_clr = 1'b1;
        step(1);
        pn_err = '0; up_err_clr = 1'b0;
        chk("pn_sticky_set_wins", 32'(pn_sticky), 32'h2);
        up_err_clr = 1'b1;
        step(1);
        up_err_clr = 1'b0;
        chk("pn_sticky_clr", 32'(pn_sticky), 0);
        pn_oos = 4'b1000; or_s = 4'b0001;
        step(1);
        pn_oos = '0; or_s = '0;
        chk("status_oos_or_hi", 32'({st_pn_oos, st_or}), 32'h3);
        step(1);
        chk("status_oos_or_lo", 32'({st_pn_oos, st_or}), 0);

        // Read timeout: req on edge 0, no acks
        c = cyc;
        up_rreq = 1'b1;
`ifdef UP_ADC_RX_AGGR_TIMEOUT_EN
        push4(1'b0, 1'b1, 32'hDEAD_DEAD, c + 1 + TO);
`endif
        step(1);
        up_rreq = 1'b0;
        step(TO + 4);
`ifdef UP_ADC_RX_AGGR_TIMEOUT_EN
        chk("timeout_flag_set", 32'(err_timeout), 1);
`else
        chk("timeout_flag_tied", 32'(err_timeout), 0);
`endif
        up_err_clr = 1'b1;
        step(1);
        up_err_clr = 1'b0;
        chk("timeout_flag_clr", 32'(err_timeout), 0);

        // Real ack on the expiry edge wins over the watchdog
        c = cyc;
        up_rreq = 1'b1;
        step(1);
        up_rreq = 1'b0;
        step(TO - 1);
        up_rack_s = 5'b10000;
        up_rdata_s[4*32 +: 32] = 32'h0000_0042;
        push4(1'b0, 1'b1, 32'h0000_0042, c + TO + 1);
        step(1);
        up_rack_s = '0; up_rdata_s = '0;
        step(3);
        chk("ack_wins_no_timeout", 32'(err_timeout), 0);

        // Reset while the write tracker waits at counter 3
        up_wreq = 1'b1; pn_err = 4'b0001;
        step(1);
        up_wreq = 1'b0; pn_err = '0;
        step(3);
        chk("pre_reset_sticky", 32'(pn_sticky), 32'h1);
        up_rstn = 1'b0;
        #1;
        chk("midrst_sticky", 32'(pn_sticky), 0);
        chk("midrst_acks", 32'({up_wack, up_rack}), 0);
        chk("midrst_rdata", up_rdata, 0);
        step(2);
        up_rstn = 1'b1;
        step(TO + 4);
        chk("post_reset_timeout", 32'(err_timeout), 0);

        // 16-channel build: common slave (index 16) forwarded unchanged
        rack16[16] = 1'b1;
        rdata16_s[16*32 +: 32] = 32'hA5A5_0001;
        rdata16_s[3*32 +: 32]  = 32'h0F0F_0F0F;
        e.v = {1'b0, 1'b1, 32'hA5A5_0001};
        e.cyc = cyc + 1;
        q16.push_back(e);
        step(1);
        rack16 = '0; rdata16_s = '0;
        step(3);

        chk("q4_drained", 32'(q4.size()), 0);
        chk("q16_drained", 32'(q16.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
